// File: rtl/tap_core_param.sv
// Parameterised IEEE 1149.1 TAP controller with IDCODE/USERCODE, a boundary-scan
// register and up to four user data registers, all clocked by TCK.
module tap_core_param #(
    parameter int          IR_WIDTH   = 4,
    parameter logic [31:0] ID_VALUE   = 32'h1000_00F1,
    parameter logic [31:0] USER_VALUE = 32'h0000_00F1,
    parameter int          BSR_WIDTH  = 10,
    parameter int          UDR_NUM    = 2,
    parameter int          UDR_WIDTH  = 8
) (
    input  logic                         TCK,
    input  logic                         TRST,
    input  logic                         TMS,
    input  logic                         TDI,
    output logic                         TDO,
    output logic                         TDO_EN,
    input  logic [BSR_WIDTH-1:0]         PIN_IN,
    input  logic [BSR_WIDTH-1:0]         CORE_IN,
    output logic [BSR_WIDTH-1:0]         PIN_OUT,
    output logic                         HIGHZ_OUT,
    input  logic [UDR_NUM*UDR_WIDTH-1:0] UDR_IN,
    output logic [UDR_NUM*UDR_WIDTH-1:0] UDR_OUT,
    output logic [3:0]                   TAP_STATE,
    output logic [IR_WIDTH-1:0]          IR_OUT
);

    typedef enum logic [3:0] {
        TLR    = 4'hF, RTI    = 4'hC, SEL_DR = 4'h7, CAP_DR = 4'h6,
        SH_DR  = 4'h2, EX1_DR = 4'h1, PS_DR  = 4'h3, EX2_DR = 4'h0,
        UPD_DR = 4'h5, SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA,
        EX1_IR = 4'h9, PS_IR  = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] OP_SAMPLE   = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] OP_EXTEST   = IR_WIDTH'(2);
    localparam logic [IR_WIDTH-1:0] OP_INTEST   = IR_WIDTH'(3);
    localparam logic [IR_WIDTH-1:0] OP_CLAMP    = IR_WIDTH'(5);
    localparam logic [IR_WIDTH-1:0] OP_IDCODE   = IR_WIDTH'(7);
    localparam logic [IR_WIDTH-1:0] OP_USERCODE = IR_WIDTH'(8);
    localparam logic [IR_WIDTH-1:0] OP_HIGHZ    = IR_WIDTH'(9);

    tap_state_e                 state_q, state_d;
    logic [IR_WIDTH-1:0]        irSh_q, ir_q;
    logic                       bypass_q;
    logic [31:0]                devSh_q;
    logic [BSR_WIDTH-1:0]       bsrSh_q, bsrUpd_q;
    logic [UDR_WIDTH-1:0]       udrSh_q  [UDR_NUM];
    logic [UDR_WIDTH-1:0]       udrOut_q [UDR_NUM];

    logic                       selDev, capUser, selBsr, capCore;
    logic [UDR_NUM-1:0]         udrSel;

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:    state_d = TMS ? TLR    : RTI;
            RTI:    state_d = TMS ? SEL_DR : RTI;
            SEL_DR: state_d = TMS ? SEL_IR : CAP_DR;
            CAP_DR: state_d = TMS ? EX1_DR : SH_DR;
            SH_DR:  state_d = TMS ? EX1_DR : SH_DR;
            EX1_DR: state_d = TMS ? UPD_DR : PS_DR;
            PS_DR:  state_d = TMS ? EX2_DR : PS_DR;
            EX2_DR: state_d = TMS ? UPD_DR : SH_DR;
            UPD_DR: state_d = TMS ? SEL_DR : RTI;
            SEL_IR: state_d = TMS ? TLR    : CAP_IR;
            CAP_IR: state_d = TMS ? EX1_IR : SH_IR;
            SH_IR:  state_d = TMS ? EX1_IR : SH_IR;
            EX1_IR: state_d = TMS ? UPD_IR : PS_IR;
            PS_IR:  state_d = TMS ? EX2_IR : PS_IR;
            EX2_IR: state_d = TMS ? UPD_IR : SH_IR;
            UPD_IR: state_d = TMS ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    // Anything not decoded here (CLAMP, HIGHZ, BYPASS, unknown) falls back to the bypass bit.
    always_comb begin
        selDev  = (ir_q == OP_IDCODE) || (ir_q == OP_USERCODE);
        capUser = (ir_q == OP_USERCODE);
        selBsr  = (ir_q == OP_SAMPLE) || (ir_q == OP_EXTEST) || (ir_q == OP_INTEST);
        capCore = (ir_q == OP_INTEST);
        udrSel  = '0;
        for (int k = 0; k < UDR_NUM; k++) begin
            udrSel[k] = (ir_q == IR_WIDTH'(10 + k));
        end
    end

    always_ff @(posedge TCK) begin
        if (TRST) begin
            state_q  <= TLR;
            ir_q     <= OP_IDCODE;
            irSh_q   <= '0;
            bypass_q <= 1'b0;
            devSh_q  <= '0;
            bsrSh_q  <= '0;
            bsrUpd_q <= '0;
            for (int k = 0; k < UDR_NUM; k++) begin
                udrSh_q[k]  <= '0;
                udrOut_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                CAP_IR: irSh_q <= IR_WIDTH'(2'b01);
                SH_IR:  irSh_q <= {TDI, irSh_q[IR_WIDTH-1:1]};
                UPD_IR: ir_q   <= irSh_q;
                CAP_DR: begin
                    if (selDev)        devSh_q  <= capUser ? USER_VALUE : ID_VALUE;
                    else if (selBsr)   bsrSh_q  <= capCore ? CORE_IN : PIN_IN;
                    else if (|udrSel) begin
                        for (int k = 0; k < UDR_NUM; k++)
                            if (udrSel[k]) udrSh_q[k] <= UDR_IN[k*UDR_WIDTH +: UDR_WIDTH];
                    end
                    else               bypass_q <= 1'b0;
                end
                SH_DR: begin
                    if (selDev)        devSh_q  <= {TDI, devSh_q[31:1]};
                    else if (selBsr)   bsrSh_q  <= {TDI, bsrSh_q[BSR_WIDTH-1:1]};
                    else if (|udrSel) begin
                        for (int k = 0; k < UDR_NUM; k++)
                            if (udrSel[k]) udrSh_q[k] <= {TDI, udrSh_q[k][UDR_WIDTH-1:1]};
                    end
                    else               bypass_q <= TDI;
                end
                UPD_DR: begin
                    if (selBsr) bsrUpd_q <= bsrSh_q;
                    for (int k = 0; k < UDR_NUM; k++)
                        if (udrSel[k]) udrOut_q[k] <= udrSh_q[k];
                end
                default: ;
            endcase
            // Walking into Test-Logic-Reset with TMS acts as a soft reset of the instruction.
            if (state_d == TLR) begin
                ir_q     <= OP_IDCODE;
                bypass_q <= 1'b0;
            end
        end
    end

    always_comb begin
        TDO = 1'b0;
        if (state_q == SH_IR) begin
            TDO = irSh_q[0];
        end else if (state_q == SH_DR) begin
            if (selDev)       TDO = devSh_q[0];
            else if (selBsr)  TDO = bsrSh_q[0];
            else if (|udrSel) begin
                for (int k = 0; k < UDR_NUM; k++)
                    if (udrSel[k]) TDO = udrSh_q[k][0];
            end
            else              TDO = bypass_q;
        end
    end

    for (genvar g = 0; g < UDR_NUM; g++) begin : g_udrOut
        assign UDR_OUT[g*UDR_WIDTH +: UDR_WIDTH] = udrOut_q[g];
    end

    assign TDO_EN    = (state_q == SH_DR) || (state_q == SH_IR);
    assign TAP_STATE = state_q;
    assign IR_OUT    = ir_q;
    assign HIGHZ_OUT = (ir_q == OP_HIGHZ);
    assign PIN_OUT   = ((ir_q == OP_EXTEST) || (ir_q == OP_CLAMP)) ? bsrUpd_q : CORE_IN;

endmodule

// File: tb/tb_tap_core_param.sv
// Directed bench for tap_core_param: walks the TAP through IR/DR scans of every
// register class and checks captured data, update latches and reset behaviour.
module tb_tap_core_param;

    logic        TCK = 1'b0;
    logic        TRST, TMS, TDI;
    logic        TDO, TDO_EN, HIGHZ_OUT;
    logic [9:0]  PIN_IN, CORE_IN, PIN_OUT;
    logic [15:0] UDR_IN, UDR_OUT;
    logic [3:0]  TAP_STATE, IR_OUT;

    int nAsserts = 0;
    int nFails   = 0;
    logic [63:0] shiftOut;
    logic [3:0]  irOut;

    tap_core_param dut (
        .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_EN(TDO_EN),
        .PIN_IN(PIN_IN), .CORE_IN(CORE_IN), .PIN_OUT(PIN_OUT), .HIGHZ_OUT(HIGHZ_OUT),
        .UDR_IN(UDR_IN), .UDR_OUT(UDR_OUT), .TAP_STATE(TAP_STATE), .IR_OUT(IR_OUT)
    );

    always #5 TCK = ~TCK;

    // One TCK rising edge with the given TMS/TDI; outputs are settled 1ns afterwards.
    task automatic applyStimulus(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // From RTI: full IR scan, returning the bits seen on TDO; ends back in RTI.
    task automatic scanIR(input logic [3:0] din, output logic [3:0] dout);
        applyStimulus(1, 0);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        for (int i = 0; i < 4; i++) begin
            dout[i] = TDO;
            applyStimulus(i == 3, din[i]);
        end
        applyStimulus(1, 0);
        applyStimulus(0, 0);
    endtask

    // From RTI: DR scan of 'width' bits, optionally detouring through Pause-DR after pauseAt bits.
    task automatic scanDR(input int width, input logic [63:0] din, input int pauseAt,
                          output logic [63:0] dout);
        dout = '0;
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        for (int i = 0; i < width; i++) begin
            dout[i] = TDO;
            applyStimulus((i == width - 1) || (i == pauseAt - 1), din[i]);
            if (i == pauseAt - 1 && i != width - 1) begin
                applyStimulus(0, 0);
                checkOutput("pause_state", 64'(TAP_STATE), 64'h3);
                checkOutput("pause_tdo", 64'(TDO), 64'h0);
                applyStimulus(0, 0);
                applyStimulus(1, 0);
                applyStimulus(0, 0);
            end
        end
        applyStimulus(1, 0);
        applyStimulus(0, 0);
    endtask

    initial begin
        TRST    = 1'b1;
        TMS     = 1'b0;
        TDI     = 1'b0;
        PIN_IN  = 10'h0F3;
        CORE_IN = 10'h155;
        UDR_IN  = {8'h81, 8'h5A};

        applyStimulus(0, 0);
        checkOutput("rst_state", 64'(TAP_STATE), 64'hF);
        checkOutput("rst_ir", 64'(IR_OUT), 64'h7);
        checkOutput("rst_tdoen", 64'(TDO_EN), 64'h0);
        checkOutput("rst_udr", 64'(UDR_OUT), 64'h0);
        TRST = 1'b0;
        applyStimulus(0, 0);
        checkOutput("rti_state", 64'(TAP_STATE), 64'hC);
        checkOutput("rti_ir", 64'(IR_OUT), 64'h7);
        checkOutput("rti_tdoen", 64'(TDO_EN), 64'h0);
        checkOutput("rti_pinout", 64'(PIN_OUT), 64'h155);

        scanDR(32, 64'h0, 0, shiftOut);
        checkOutput("idcode", shiftOut, 64'h1000_00F1);

        scanIR(4'hF, irOut);
        checkOutput("ir_capture", 64'(irOut), 64'h1);
        checkOutput("ir_bypass", 64'(IR_OUT), 64'hF);

        // 1-bit bypass path: TDI appears on TDO one edge later.
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        checkOutput("byp_shdr_state", 64'(TAP_STATE), 64'h2);
        checkOutput("byp_tdoen", 64'(TDO_EN), 64'h1);
        checkOutput("byp_cap", 64'(TDO), 64'h0);
        applyStimulus(0, 1);
        checkOutput("byp_delay1", 64'(TDO), 64'h1);
        applyStimulus(0, 0);
        checkOutput("byp_delay0", 64'(TDO), 64'h0);
        applyStimulus(1, 1);
        checkOutput("ex1dr_tdo", 64'(TDO), 64'h0);
        applyStimulus(1, 0);
        applyStimulus(0, 0);

        scanIR(4'h2, irOut);
        checkOutput("extest_ir", 64'(IR_OUT), 64'h2);
        scanDR(10, 64'h2A5, 0, shiftOut);
        checkOutput("extest_cap", shiftOut, 64'h0F3);
        checkOutput("extest_pin", 64'(PIN_OUT), 64'h2A5);

        scanIR(4'h9, irOut);
        checkOutput("highz_out", 64'(HIGHZ_OUT), 64'h1);
        checkOutput("highz_pin", 64'(PIN_OUT), 64'h155);

        scanIR(4'h5, irOut);
        checkOutput("clamp_highz", 64'(HIGHZ_OUT), 64'h0);
        checkOutput("clamp_pin", 64'(PIN_OUT), 64'h2A5);

        scanIR(4'h3, irOut);
        scanDR(10, 64'h00F, 0, shiftOut);
        checkOutput("intest_cap", shiftOut, 64'h155);
        checkOutput("intest_pin", 64'(PIN_OUT), 64'h155);
        scanIR(4'h5, irOut);
        checkOutput("clamp_pin2", 64'(PIN_OUT), 64'h00F);

        scanIR(4'h4, irOut);
        scanDR(2, 64'h1, 0, shiftOut);
        checkOutput("unknown_bypass", shiftOut, 64'h2);

        scanIR(4'h8, irOut);
        scanDR(32, 64'h0, 0, shiftOut);
        checkOutput("usercode", shiftOut, 64'h0000_00F1);

        scanIR(4'hA, irOut);
        scanDR(8, 64'hC3, 0, shiftOut);
        checkOutput("user0_cap", shiftOut, 64'h5A);
        checkOutput("user0_out", 64'(UDR_OUT), 64'h00C3);

        scanIR(4'hB, irOut);
        scanDR(8, 64'h3C, 3, shiftOut);
        checkOutput("user1_cap", shiftOut, 64'h81);
        checkOutput("user1_out", 64'(UDR_OUT), 64'h3CC3);

        for (int i = 0; i < 5; i++) applyStimulus(1, 0);
        checkOutput("tms_tlr_state", 64'(TAP_STATE), 64'hF);
        checkOutput("tms_tlr_ir", 64'(IR_OUT), 64'h7);
        checkOutput("tms_tlr_udr", 64'(UDR_OUT), 64'h3CC3);
        applyStimulus(0, 0);

        // TRST in the middle of a 32-bit IDCODE shift.
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1);
        TRST = 1'b1;
        applyStimulus(0, 0);
        checkOutput("trst_state", 64'(TAP_STATE), 64'hF);
        checkOutput("trst_tdoen", 64'(TDO_EN), 64'h0);
        checkOutput("trst_udr", 64'(UDR_OUT), 64'h0);
        checkOutput("trst_tdo", 64'(TDO), 64'h0);
        TRST = 1'b0;
        applyStimulus(0, 0);
        scanIR(4'h5, irOut);
        checkOutput("trst_bsr_latch", 64'(PIN_OUT), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/tap_core_param.md
TAP_CORE_PARAM -- requirements
Module: tap_core_param

Interface
REQ-001 SHALL have parameter IR_WIDTH, default 4, instruction register length (>=4).
REQ-002 SHALL have parameter ID_VALUE, default 32'h1000_00F1, IDCODE capture value (bit0 = 1).
REQ-003 SHALL have parameter USER_VALUE, default 32'h0000_00F1, USERCODE capture value.
REQ-004 SHALL have parameter BSR_WIDTH, default 10, boundary-scan cell count.
REQ-005 SHALL have parameter UDR_NUM, default 2, number of user data registers (1..4).
REQ-006 SHALL have parameter UDR_WIDTH, default 8, length of each user data register.
REQ-007 SHALL have port TCK  input  1  sole clock; all state changes on rising edge.
REQ-008 SHALL have port TRST  input  1  synchronous active-high reset.
REQ-009 SHALL have ports TMS, TDI  input  1  JTAG mode select and serial data in.
REQ-010 SHALL have port TDO  output  1  serial data out; TDO_EN  output  1  high in Shift-DR/Shift-IR only.
REQ-011 SHALL have ports PIN_IN, CORE_IN  input  BSR_WIDTH  pad-side and core-side values.
REQ-012 SHALL have ports PIN_OUT  output  BSR_WIDTH  pad drive; HIGHZ_OUT  output  1  pad tri-state request.
REQ-013 SHALL have ports UDR_IN  input  UDR_NUM*UDR_WIDTH  user capture data; UDR_OUT  output  UDR_NUM*UDR_WIDTH  user update data.
REQ-014 SHALL have ports TAP_STATE  output  4  current state; IR_OUT  output  IR_WIDTH  active instruction.

Function
REQ-015 SHALL implement the 16-state IEEE 1149.1 FSM with standard encoding: TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PsDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PsIR=B, Ex2IR=8, UpdIR=D.
REQ-016 SHALL take the standard TMS-driven transitions, one per rising TCK edge; five TMS=1 edges reach TLR from any state.
REQ-017 SHALL decode opcodes zero-extended to IR_WIDTH: SAMPLE=1, EXTEST=2, INTEST=3, CLAMP=5, IDCODE=7, USERCODE=8, HIGHZ=9, USERk=A+k (k<UDR_NUM), BYPASS=all ones; any other code behaves as BYPASS.
REQ-018 In CapIR, IR shift register SHALL load {0..0,2'b01}; in ShIR, shift right with TDI into MSB; in UpdIR, copy to IR_OUT.
REQ-019 In CapDR the selected DR SHALL load: IDCODE->ID_VALUE, USERCODE->USER_VALUE, BYPASS->0, SAMPLE/EXTEST->PIN_IN, INTEST->CORE_IN, USERk->UDR_IN slice k, CLAMP/HIGHZ->bypass 0.
REQ-020 In ShDR only the selected DR SHALL shift right, TDI into MSB; unselected registers hold.
REQ-021 TDO SHALL equal LSB of IR shift register in ShIR, LSB of selected DR in ShDR, 0 otherwise; registered sources only, no latency beyond the shift register.
REQ-022 In UpdDR: BSR update latch <- BSR shift register for SAMPLE/EXTEST/INTEST; UDR_OUT slice k <- USERk shift register; other instructions leave latches unchanged.
REQ-023 PIN_OUT SHALL be BSR update latch for EXTEST/CLAMP, else CORE_IN; HIGHZ_OUT SHALL be 1 only while IR_OUT=HIGHZ.
REQ-024 Pause/Exit states SHALL hold all shift registers; re-entering Shift SHALL continue without recapture.
REQ-025 Entering TLR (via TMS) SHALL set IR_OUT=IDCODE and clear BYPASS register; BSR and UDR update latches hold.
REQ-026 Length of a full DR scan SHALL equal 1, 32, 32, BSR_WIDTH, or UDR_WIDTH bits for the respective instruction.

Reset
REQ-027 TRST=1 at a rising TCK edge SHALL force TAP_STATE=F, IR_OUT=IDCODE, IR shift=0, all DR shift registers=0, BSR update latch=0, UDR_OUT=0, TDO_EN=0; TRST has priority over TMS, including mid-shift.

Verification
REQ-028 TRST pulse then TMS=0 -> TAP_STATE C, IR_OUT 7, TDO_EN 0, PIN_OUT=CORE_IN.
REQ-029 From RTI scan DR 32 bits, TDI=0 -> TDO returns 32'h1000_00F1 LSB first.
REQ-030 Scan IR with TDI=4'hF -> TDO shifts out 0001 (LSB first 1,0,0,0); IR_OUT=F after UpdIR; 1-bit DR scan shows TDI delayed one edge.
REQ-031 Load EXTEST, shift 10'h2A5 into BSR, UpdDR -> PIN_OUT=10'h2A5; then HIGHZ -> HIGHZ_OUT 1.
REQ-032 Load USER1 (4'hB), shift 8'h3C with UDR_IN slice1=8'h81 -> TDO yields 8'h81, UDR_OUT slice1=8'h3C, slice0 unchanged.
REQ-033 Assert TRST after 5 bits of a 32-bit ShDR -> next edge TAP_STATE F, TDO_EN 0, UDR_OUT 0.
